// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg
// Shared definitions for the 4-wire SPI LCD link: panel command opcodes,
// default panel geometry, decoder state encoding and a window helper.
// Used by both the screen driver and the panel emulator.
// Rev 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // ST7735-class command opcodes
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // Default panel geometry
  localparam int LCD_WIDTH  = 128;
  localparam int LCD_HEIGHT = 160;

  // Command decoder states
  typedef enum logic [2:0] {
    DEC_IDLE     = 3'd0,
    DEC_CASET    = 3'd1,
    DEC_RASET    = 3'd2,
    DEC_RAMWR_HI = 3'd3,
    DEC_RAMWR_LO = 3'd4
  } dec_state_e;

  // Effective window end: an inverted window (start > end) collapses to
  // the single line at its start.
  function automatic logic [7:0] win_end(input logic [7:0] s, input logic [7:0] e);
    return (s > e) ? s : e;
  endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// ============================================================================
// spi_byte_rx
// SPI slave byte receiver. All five LCD pins are brought into the clk domain
// through a SYNC_STAGES flip-flop chain; rising edges of the synced SPI clock
// while chip select is low shift MOSI in MSB first. The 8th bit produces a
// one-cycle byte strobe together with the register-select level seen with
// that last bit.
//
// Ports
//   clk_i          system clock (at least 4x the SPI clock)
//   reset_n_i      synchronous active-low reset
//   lcd_clk_i      SPI clock, idle low, sampled on its rising edge
//   lcd_mosi_i     serial data, MSB first
//   lcd_cs_i       chip select, active low
//   lcd_rs_i       0 = command, 1 = data
//   lcd_reset_i    panel reset, active low
//   byte_valid_o   one-cycle strobe, byte received
//   byte_data_o    received byte, held until the next strobe
//   byte_is_data_o register-select captured with the byte
//   panel_rst_o    synced panel reset request (active high)
// Rev 1.0 - initial release
// ============================================================================
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       lcd_clk_i,
  input  logic       lcd_mosi_i,
  input  logic       lcd_cs_i,
  input  logic       lcd_rs_i,
  input  logic       lcd_reset_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_is_data_o,
  output logic       panel_rst_o
);

  // Pin bundle order {reset, rs, cs, mosi, clk}; idle levels are
  // reset high, cs high, everything else low.
  localparam logic [4:0] SYNC_IDLE = 5'b10100;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0] pins_w;

  assign pins_w = {lcd_reset_i, lcd_rs_i, lcd_cs_i, lcd_mosi_i, lcd_clk_i};

  // The chain itself is cleared only by the system reset so that the synced
  // panel reset can in turn hold the rest of the design.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync_q <= {SYNC_STAGES{SYNC_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins_w};
    end
  end

  logic sclk_w, smosi_w, scs_w, srs_w, sreset_n_w;
  assign {sreset_n_w, srs_w, scs_w, smosi_w, sclk_w} = sync_q[SYNC_STAGES-1];

  logic rst_w;
  assign rst_w       = !reset_n_i || !sreset_n_w;
  assign panel_rst_o = !sreset_n_w;

  logic       sclk_prev_q;
  logic       scs_prev_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       byte_valid_q;
  logic [7:0] byte_data_q;
  logic       byte_is_data_q;

  logic rise_w, shift_en_w;
  assign rise_w = sclk_w & ~sclk_prev_q;
  // cs is qualified with its previous value as well, so a final clock edge
  // that lands in the same cycle as the cs rise still completes the byte.
  assign shift_en_w = rise_w & (~scs_w | ~scs_prev_q);

  always_ff @(posedge clk_i) begin
    if (rst_w) begin
      sclk_prev_q    <= 1'b0;
      scs_prev_q     <= 1'b1;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 7'd0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'd0;
      byte_is_data_q <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_w;
      scs_prev_q   <= scs_w;
      byte_valid_q <= 1'b0;
      if (shift_en_w) begin
        shift_q <= {shift_q[5:0], smosi_w};
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q   <= 1'b1;
          byte_data_q    <= {shift_q, smosi_w};
          byte_is_data_q <= srs_w;
          bit_cnt_q      <= 3'd0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end else if (scs_w) begin
        // Deselect throws away any partial byte.
        bit_cnt_q <= 3'd0;
      end
    end
  end

  assign byte_valid_o   = byte_valid_q;
  assign byte_data_o    = byte_data_q;
  assign byte_is_data_o = byte_is_data_q;

endmodule : spi_byte_rx
`default_nettype wire

// File: rtl/spi_lcd_sink.sv
`default_nettype none
// ============================================================================
// spi_lcd_sink
// Panel-side emulation of an ST7735-class LCD controller. Receives bytes over
// the 4-wire SPI link, decodes SWRESET/SLPIN/SLPOUT/CASET/RASET/RAMWR and
// emits framebuffer pixel writes with a windowed auto-advancing cursor.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   lcd_clk, lcd_mosi   SPI clock (idle low) and data (MSB first)
//   lcd_cs, lcd_rs      chip select (active low), command/data select
//   lcd_reset           panel reset, active low
//   byte_valid/byte_data/byte_is_data   raw received byte stream
//   pix_we, pix_x, pix_y, pix_data      pixel write port (RGB565)
//   sleeping            sleep status flag
// Rev 1.0 - initial release
// ============================================================================
module spi_lcd_sink
  import lcd_pkg::*;
#(
  parameter int WIDTH       = LCD_WIDTH,
  parameter int HEIGHT      = LCD_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lcd_clk,
  input  logic        lcd_mosi,
  input  logic        lcd_cs,
  input  logic        lcd_rs,
  input  logic        lcd_reset,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        pix_we,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        sleeping
);

  localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
  localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

  logic       byte_valid_w;
  logic [7:0] byte_data_w;
  logic       byte_is_data_w;
  logic       panel_rst_w;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .lcd_clk_i      (lcd_clk),
    .lcd_mosi_i     (lcd_mosi),
    .lcd_cs_i       (lcd_cs),
    .lcd_rs_i       (lcd_rs),
    .lcd_reset_i    (lcd_reset),
    .byte_valid_o   (byte_valid_w),
    .byte_data_o    (byte_data_w),
    .byte_is_data_o (byte_is_data_w),
    .panel_rst_o    (panel_rst_w)
  );

  assign byte_valid   = byte_valid_w;
  assign byte_data    = byte_data_w;
  assign byte_is_data = byte_is_data_w;

  logic rst_w;
  assign rst_w = !reset_n || panel_rst_w;

  dec_state_e  state_q, state_d;
  logic [1:0]  arg_cnt_q, arg_cnt_d;
  logic [7:0]  arg_lo_q, arg_lo_d;
  logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  hi_q, hi_d;
  logic        sleeping_q, sleeping_d;
  logic        pix_we_q, pix_we_d;
  logic [7:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;

  logic in_range_w, last_col_w, last_row_w;
  assign in_range_w = ({1'b0, x_q} < 9'(WIDTH)) && ({1'b0, y_q} < 9'(HEIGHT));
  assign last_col_w = (x_q == win_end(xs_q, xe_q)) || (x_q == X_MAX);
  assign last_row_w = (y_q == win_end(ys_q, ye_q)) || (y_q == Y_MAX);

  always_ff @(posedge clk) begin
    if (rst_w) begin
      state_q    <= DEC_IDLE;
      arg_cnt_q  <= 2'd0;
      arg_lo_q   <= 8'd0;
      xs_q       <= 8'd0;
      xe_q       <= X_MAX;
      ys_q       <= 8'd0;
      ye_q       <= Y_MAX;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      hi_q       <= 8'd0;
      sleeping_q <= 1'b1;
      pix_we_q   <= 1'b0;
      pix_x_q    <= 8'd0;
      pix_y_q    <= 8'd0;
      pix_data_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      arg_cnt_q  <= arg_cnt_d;
      arg_lo_q   <= arg_lo_d;
      xs_q       <= xs_d;
      xe_q       <= xe_d;
      ys_q       <= ys_d;
      ye_q       <= ye_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hi_q       <= hi_d;
      sleeping_q <= sleeping_d;
      pix_we_q   <= pix_we_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      pix_data_q <= pix_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arg_cnt_d  = arg_cnt_q;
    arg_lo_d   = arg_lo_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ys_d       = ys_q;
    ye_d       = ye_q;
    x_d        = x_q;
    y_d        = y_q;
    hi_d       = hi_q;
    sleeping_d = sleeping_q;
    pix_we_d   = 1'b0;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    pix_data_d = pix_data_q;

    if (byte_valid_w) begin
      if (!byte_is_data_w) begin
        // Every command byte aborts whatever was in progress.
        state_d   = DEC_IDLE;
        arg_cnt_d = 2'd0;
        case (byte_data_w)
          CMD_SWRESET: begin
            xs_d       = 8'd0;
            xe_d       = X_MAX;
            ys_d       = 8'd0;
            ye_d       = Y_MAX;
            sleeping_d = 1'b1;
          end
          CMD_SLPIN:  sleeping_d = 1'b1;
          CMD_SLPOUT: sleeping_d = 1'b0;
          CMD_CASET:  state_d = DEC_CASET;
          CMD_RASET:  state_d = DEC_RASET;
          CMD_RAMWR: begin
            state_d = DEC_RAMWR_HI;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          DEC_CASET, DEC_RASET: begin
            // Argument order: start hi, start lo, end hi, end lo. Only the
            // low bytes matter; the window commits on the last one.
            arg_cnt_d = 2'(arg_cnt_q + 2'd1);
            if (arg_cnt_q == 2'd1) begin
              arg_lo_d = byte_data_w;
            end
            if (arg_cnt_q == 2'd3) begin
              state_d = DEC_IDLE;
              if (state_q == DEC_CASET) begin
                xs_d = arg_lo_q;
                xe_d = byte_data_w;
              end else begin
                ys_d = arg_lo_q;
                ye_d = byte_data_w;
              end
            end
          end
          DEC_RAMWR_HI: begin
            hi_d    = byte_data_w;
            state_d = DEC_RAMWR_LO;
          end
          DEC_RAMWR_LO: begin
            state_d    = DEC_RAMWR_HI;
            pix_we_d   = in_range_w;
            pix_x_d    = x_q;
            pix_y_d    = y_q;
            pix_data_d = {hi_q, byte_data_w};
            // Clipped pixels still move the cursor.
            if (last_col_w) begin
              x_d = xs_q;
              y_d = last_row_w ? ys_q : (y_q + 8'd1);
            end else begin
              x_d = x_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pix_we   = pix_we_q;
  assign pix_x    = pix_x_q;
  assign pix_y    = pix_y_q;
  assign pix_data = pix_data_q;
  assign sleeping = sleeping_q;

endmodule : spi_lcd_sink
`default_nettype wire

// File: tb/tb_spi_lcd_sink.sv
`default_nettype none
// ============================================================================
// tb_spi_lcd_sink
// Scoreboard bench for spi_lcd_sink: every byte sent and every pixel expected
// is queued by the stimulus; an independent monitor pops and compares on
// each byte_valid / pix_we strobe.
// Rev 1.0 - initial release
// ============================================================================
module tb_spi_lcd_sink;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lcd_clk = 1'b0;
  logic        lcd_mosi = 1'b0;
  logic        lcd_cs = 1'b1;
  logic        lcd_rs = 1'b0;
  logic        lcd_reset = 1'b1;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_is_data;
  logic        pix_we;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;
  logic        sleeping;

  always #5 clk = ~clk;

  spi_lcd_sink #(
    .WIDTH       (128),
    .HEIGHT      (160),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .lcd_clk      (lcd_clk),
    .lcd_mosi     (lcd_mosi),
    .lcd_cs       (lcd_cs),
    .lcd_rs       (lcd_rs),
    .lcd_reset    (lcd_reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .pix_we       (pix_we),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .sleeping     (sleeping)
  );

  typedef struct packed {
    logic       is_data;
    logic [7:0] d;
  } byte_t;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
  } pix_t;

  byte_t exp_bytes[$];
  pix_t  exp_pix[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  byte_t eb;
  pix_t  ep;
  always @(negedge clk) begin
    if (byte_valid === 1'b1) begin
      n_tests++;
      if (exp_bytes.size() == 0) begin
        n_fail++;
        $display("FAIL byte_unexpected: got %0h rs=%0b, required no byte", byte_data, byte_is_data);
      end else begin
        eb = exp_bytes.pop_front();
        if ({byte_is_data, byte_data} !== {eb.is_data, eb.d}) begin
          n_fail++;
          $display("FAIL byte_rx: got %0h rs=%0b, required %0h rs=%0b",
                   byte_data, byte_is_data, eb.d, eb.is_data);
        end
      end
    end
    if (pix_we === 1'b1) begin
      n_tests++;
      if (exp_pix.size() == 0) begin
        n_fail++;
        $display("FAIL pix_unexpected: got (%0d,%0d)=%0h, required no write", pix_x, pix_y, pix_data);
      end else begin
        ep = exp_pix.pop_front();
        if ({pix_x, pix_y, pix_data} !== {ep.x, ep.y, ep.d}) begin
          n_fail++;
          $display("FAIL pix_write: got (%0d,%0d)=%0h, required (%0d,%0d)=%0h",
                   pix_x, pix_y, pix_data, ep.x, ep.y, ep.d);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI at clk/8: 4 clk low, 4 clk high per bit.
  task automatic send_bits(input logic [7:0] b, input logic rs, input int nbits);
    lcd_rs = rs;
    for (int i = 7; i > 7 - nbits; i--) begin
      lcd_mosi = b[i];
      wait_clk(4);
      lcd_clk = 1'b1;
      wait_clk(4);
      lcd_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic rs);
    byte_t t;
    t.d       = b;
    t.is_data = rs;
    exp_bytes.push_back(t);
    send_bits(b, rs, 8);
  endtask

  task automatic cmd(input logic [7:0] b);
    send(b, 1'b0);
  endtask

  task automatic dat(input logic [7:0] b);
    send(b, 1'b1);
  endtask

  task automatic pixel(input logic [15:0] v);
    dat(v[15:8]);
    dat(v[7:0]);
  endtask

  task automatic expect_pix(input logic [7:0] x, input logic [7:0] y, input logic [15:0] d);
    pix_t p;
    p.x = x;
    p.y = y;
    p.d = d;
    exp_pix.push_back(p);
  endtask

  task automatic window(input logic [7:0] c, input logic [7:0] s, input logic [7:0] e);
    cmd(c);
    dat(8'h00);
    dat(s);
    dat(8'h00);
    dat(e);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // System reset held for one clock edge.
    wait_clk(1);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_byte_data", {24'd0, byte_data}, 32'd0);
    check("rst_byte_is_data", {31'd0, byte_is_data}, 32'd0);
    check("rst_pix_we", {31'd0, pix_we}, 32'd0);
    check("rst_pix_x", {24'd0, pix_x}, 32'd0);
    check("rst_pix_y", {24'd0, pix_y}, 32'd0);
    check("rst_pix_data", {16'd0, pix_data}, 32'd0);
    check("rst_sleeping", {31'd0, sleeping}, 32'd1);
    reset_n = 1'b1;
    wait_clk(4);

    // Single data byte.
    lcd_cs = 1'b0;
    wait_clk(2);
    dat(8'hA5);
    wait_clk(8);
    lcd_cs = 1'b1;
    wait_clk(6);

    // Partial byte discarded by deselect, then a full byte.
    lcd_cs = 1'b0;
    wait_clk(2);
    send_bits(8'hFF, 1'b1, 5);
    wait_clk(2);
    lcd_cs = 1'b1;
    wait_clk(6);
    lcd_cs = 1'b0;
    wait_clk(2);
    dat(8'h3C);
    wait_clk(6);

    // Sleep out, then panel reset pulse brings everything back.
    cmd(8'h11);
    wait_clk(6);
    check("slpout_sleeping", {31'd0, sleeping}, 32'd0);
    lcd_reset = 1'b0;
    wait_clk(6);
    check("lcdrst_sleeping", {31'd0, sleeping}, 32'd1);
    check("lcdrst_byte_data", {24'd0, byte_data}, 32'd0);
    check("lcdrst_byte_valid", {31'd0, byte_valid}, 32'd0);
    lcd_reset = 1'b1;
    wait_clk(6);

    // 2x2 window with row wrap.
    window(8'h2A, 8'd2, 8'd3);
    window(8'h2B, 8'd5, 8'd6);
    cmd(8'h2C);
    expect_pix(8'd2, 8'd5, 16'hF800);
    expect_pix(8'd3, 8'd5, 16'hF801);
    expect_pix(8'd2, 8'd6, 16'hF802);
    expect_pix(8'd3, 8'd6, 16'hF803);
    expect_pix(8'd2, 8'd5, 16'hF804);
    for (int i = 0; i < 5; i++) pixel(16'hF800 + 16'(i));

    // Window past the right edge: column 127 wraps to xs.
    window(8'h2A, 8'h7E, 8'h81);
    cmd(8'h2C);
    expect_pix(8'd126, 8'd5, 16'h1111);
    expect_pix(8'd127, 8'd5, 16'h2222);
    expect_pix(8'd126, 8'd6, 16'h3333);
    expect_pix(8'd127, 8'd6, 16'h4444);
    pixel(16'h1111);
    pixel(16'h2222);
    pixel(16'h3333);
    pixel(16'h4444);

    // Window entirely off-panel: no writes at all.
    window(8'h2A, 8'h90, 8'h91);
    cmd(8'h2C);
    pixel(16'hAAAA);
    pixel(16'hBBBB);

    // Odd HI byte dropped by an intervening command.
    window(8'h2A, 8'd4, 8'd9);
    cmd(8'h2C);
    dat(8'h12);
    cmd(8'h00);
    cmd(8'h2C);
    expect_pix(8'd4, 8'd5, 16'h3456);
    dat(8'h34);
    dat(8'h56);

    // CASET aborted after two bytes keeps the 4..9 window.
    cmd(8'h2A);
    dat(8'h00);
    dat(8'h10);
    cmd(8'h2C);
    expect_pix(8'd4, 8'd5, 16'h0001);
    expect_pix(8'd5, 8'd5, 16'h0002);
    pixel(16'h0001);
    pixel(16'h0002);

    // SWRESET restores the full window and the sleep flag.
    cmd(8'h11);
    wait_clk(6);
    check("slpout2_sleeping", {31'd0, sleeping}, 32'd0);
    cmd(8'h01);
    wait_clk(6);
    check("swreset_sleeping", {31'd0, sleeping}, 32'd1);
    cmd(8'h2C);
    expect_pix(8'd0, 8'd0, 16'hBEEF);
    pixel(16'hBEEF);

    // Inverted column window acts as a single column; a deselect between
    // the two halves of a pixel keeps the decoder state.
    window(8'h2A, 8'd8, 8'd3);
    cmd(8'h2C);
    expect_pix(8'd8, 8'd0, 16'h1234);
    expect_pix(8'd8, 8'd1, 16'h5678);
    dat(8'h12);
    wait_clk(4);
    lcd_cs = 1'b1;
    wait_clk(6);
    lcd_cs = 1'b0;
    wait_clk(2);
    dat(8'h34);
    pixel(16'h5678);
    dat(8'h99);
    cmd(8'h10);
    dat(8'h77);
    wait_clk(6);
    check("slpin_sleeping", {31'd0, sleeping}, 32'd1);

    lcd_cs = 1'b1;
    wait_clk(20);
    check("bytes_outstanding", 32'(exp_bytes.size()), 32'd0);
    check("pixels_outstanding", 32'(exp_pix.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_spi_lcd_sink
`default_nettype wire
